aes_round_key_reader: RTL and testbench
=======================================

Name: aes_round_key_reader

Overview:
- Consumer end of the key-expansion write interface: holds the 15-entry round-key memory with per-entry valid bits, filled by the key-expansion writer.
- Streams round keys in round order to the AES cipher core over a valid/ready handshake.
- Encrypt order is index 0..Nr; decrypt order is Nr..0.
- Stalls per key until that entry's valid bit is set, so the cipher can start before expansion finishes.

Parameters:
- KEY_W, 128, round-key width.
- DEPTH, 15, entries (max Nr+1 for AES-256).
- ADDR_W, 4, entry index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- wr_valid  in  1  writer strobe: store wr_subkey at wr_addr this cycle
- wr_addr  in  ADDR_W  entry index from key expansion
- wr_subkey  in  KEY_W  round key data
- clr_valid  in  1  new key accepted by writer; invalidate all entries
- key_len  in  2  01=128, 10=192, 11=256, 00=none; sampled on start
- start  in  1  one-cycle pulse: begin a stream
- decrypt  in  1  sampled on start; 1 selects reverse order
- rk_ready  in  1  cipher core accepts rk_data
- rk_valid  out  1  rk_data/rk_idx valid
- rk_data  out  KEY_W  round key
- rk_idx  out  ADDR_W  entry index of rk_data
- rk_last  out  1  qualifies the final key of the stream
- busy  out  1  stream in progress
- done  out  1  one-cycle pulse after the last handshake
- err  out  1  one-cycle pulse: bad key_len or abort

Behaviour:
- Reset (reset=0 at posedge): all outputs 0, all valid bits 0, FSM in IDLE. Memory contents are not cleared.
- Write side, every cycle:
  - clr_valid clears all valid bits.
  - wr_valid with wr_addr<=14 writes mem and sets vbit[wr_addr].
  - When both occur, the clear applies first, then the write, so vbit[wr_addr]=1.
  - wr_addr 15 is ignored.
- Nr: 10/12/14 for key_len 01/10/11.
  - Encrypt: first=0, last=Nr, step +1.
  - Decrypt: first=Nr, last=0, step -1.
- FSM states: IDLE, WAIT, PRESENT.
- IDLE:
  - start with key_len!=00: latch len/dir, idx<=first, busy<=1, go to WAIT.
  - start with key_len==00: err pulse, stay in IDLE.
  - start while busy is ignored.
- WAIT:
  - vbit[idx]=1: load rk_data<=mem[idx], rk_idx<=idx, rk_valid<=1, go to PRESENT.
  - Minimum latency: start at edge t gives rk_valid at t+2.
  - A write to idx in the same cycle is not forwarded; it is seen the next cycle.
- PRESENT:
  - rk_data/rk_idx/rk_last are held stable while rk_valid & !rk_ready.
  - On handshake with idx==last: rk_valid<=0, done<=1, busy<=0, go to IDLE.
  - On handshake with idx!=last and vbit[next] already set: load the next key directly. Back-to-back throughput is 1 key per cycle.
  - On handshake otherwise: rk_valid<=0, go to WAIT with idx<=next.
- Abort: clr_valid while busy gives rk_valid<=0, busy<=0, err pulse, go to IDLE. Abort takes priority over handshake/done in the same cycle.
- rk_last = rk_valid & (rk_idx==last).
- Reset mid-stream returns to IDLE immediately and clears all valid bits.
- Index arithmetic is ADDR_W unsigned. It never wraps because last bounds both directions.

Decomposition:
- Shared package aes_key_pkg:
  - KEY_LEN_128/192/256/NONE encodings.
  - NR_128/192/256 constants.
  - nr_of(key_len) function.
  - KEY_W/ADDR_W/DEPTH defaults.
- One natural sub-module, aes_rkey_mem: DEPTH x KEY_W register file with valid bits, clear/write priority and a combinational read port.
- The FSM sequencer stays in the top module.

Test Plan:
- Fill entries 0..10 (key_len=01) with mem[i]=i repeated as bytes, start decrypt=0, rk_ready=1 → 11 consecutive-cycle handshakes with rk_idx 0..10, rk_last only at idx 10, done 1 cycle later, first rk_valid exactly 2 cycles after start.
- Empty memory, start with key_len=11, decrypt=1, then write entries 0..14 one per 3 cycles → first key idx 14 emitted only after entry 14 is written, then 14 down to 0, no duplicates or skips.
- key_len=10 encrypt, rk_ready toggled 1010... → rk_data stable whenever rk_valid & !rk_ready, 13 keys (idx 0..12), done once.
- Streaming with key_len=01; assert clr_valid after 4 handshakes → err pulse, rk_valid=0 next cycle, busy=0; a subsequent start waits in WAIT.
- Start with key_len=00 → single err pulse, busy stays 0, no rk_valid. Same-cycle clr_valid + wr_valid at addr 3 → only vbit[3]=1. wr_addr=15 → no vbit change.
- Assert reset=0 mid-stream at idx 5 → next cycle all outputs 0, FSM IDLE, all vbits 0.

Source files
------------

// File: rtl/aes_round_key_reader_pkg.sv
// Shared AES round-key reader types, sizes and key-length decode.
// Imported by the key memory, the handshake interface and the sequencer.
package aes_key_pkg;

   localparam int KEY_W  = 128;
   localparam int DEPTH  = 15;
   localparam int ADDR_W = 4;

   typedef enum logic [1:0] {
      KEY_LEN_NONE = 2'b00,
      KEY_LEN_128  = 2'b01,
      KEY_LEN_192  = 2'b10,
      KEY_LEN_256  = 2'b11
   } key_len_e;

   localparam logic [ADDR_W-1:0] NR_128 = 4'd10;
   localparam logic [ADDR_W-1:0] NR_192 = 4'd12;
   localparam logic [ADDR_W-1:0] NR_256 = 4'd14;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_PRESENT
   } rk_state_e;

   function automatic logic [ADDR_W-1:0] nr_of(
      input logic [1:0] key_len
   );
      logic [ADDR_W-1:0] nr;
      nr = '0;
      unique case (key_len)
         KEY_LEN_128:  nr = NR_128;
         KEY_LEN_192:  nr = NR_192;
         KEY_LEN_256:  nr = NR_256;
         KEY_LEN_NONE: nr = '0;
      endcase
      return nr;
   endfunction

endpackage

// File: rtl/aes_round_key_reader_if.sv
// Write port from key expansion, stream control and the round-key
// valid/ready stream towards the cipher core.
interface aes_round_key_reader_if;
   import aes_key_pkg::*;

   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [KEY_W-1:0]  wr_subkey;
   logic              clr_valid;
   logic [1:0]        key_len;
   logic              start;
   logic              decrypt;
   logic              rk_ready;
   logic              rk_valid;
   logic [KEY_W-1:0]  rk_data;
   logic [ADDR_W-1:0] rk_idx;
   logic              rk_last;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output wr_valid, wr_addr, wr_subkey, clr_valid,
      output key_len, start, decrypt, rk_ready,
      input  rk_valid, rk_data, rk_idx, rk_last,
      input  busy, done, err
   );

   modport slave (
      input  wr_valid, wr_addr, wr_subkey, clr_valid,
      input  key_len, start, decrypt, rk_ready,
      output rk_valid, rk_data, rk_idx, rk_last,
      output busy, done, err
   );

endinterface

// File: rtl/aes_round_key_reader_mem.sv
// Round-key register file with per-entry valid bits.
// Clear lands before a same-cycle write; out-of-range indices read as empty.
module aes_rkey_mem
   import aes_key_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [KEY_W-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [KEY_W-1:0]  rdata_o,
   output logic              rvalid_o
);

   logic [KEY_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0] vbit_q;
   logic [DEPTH-1:0] vbit_d;
   logic             wr_ok;
   logic             rd_ok;

   assign wr_ok = we_i & (waddr_i < ADDR_W'(DEPTH));
   assign rd_ok = raddr_i < ADDR_W'(DEPTH);

   always_comb begin
      vbit_d = vbit_q;
      if (clr_i) vbit_d = '0;
      if (wr_ok) vbit_d[waddr_i] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) vbit_q <= '0;
      else         vbit_q <= vbit_d;
   end

   // Data is deliberately not reset; only the valid bits gate its use.
   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o  = rd_ok ? mem_q[raddr_i] : '0;
   assign rvalid_o = rd_ok & vbit_q[raddr_i];

endmodule

// File: rtl/aes_round_key_reader.sv
// Streams stored round keys to the cipher in round order, waiting on each
// entry's valid bit so decryption or encryption can overlap key expansion.
module aes_round_key_reader
   import aes_key_pkg::*;
(
   input logic                   clk,
   input logic                   reset,
   aes_round_key_reader_if.slave bus
);

   rk_state_e         state_q;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] last_q;
   logic              dir_q;
   logic              busy_q;
   logic              rk_valid_q;
   logic [KEY_W-1:0]  rk_data_q;
   logic [ADDR_W-1:0] rk_idx_q;
   logic              done_q;
   logic              err_q;

   logic [ADDR_W-1:0] nxt;
   logic [ADDR_W-1:0] raddr;
   logic [ADDR_W-1:0] nr_s;
   logic [KEY_W-1:0]  rd_data;
   logic              rd_vld;
   logic              hs;

   assign nxt   = dir_q ? idx_q - ADDR_W'(1) : idx_q + ADDR_W'(1);
   assign nr_s  = nr_of(bus.key_len);
   assign hs    = rk_valid_q & bus.rk_ready;

   // While presenting, look ahead at the next entry for back-to-back loads.
   assign raddr = (state_q == S_PRESENT) ? nxt : idx_q;

   aes_rkey_mem u_mem (
      .clk_i    (clk),
      .rst_ni   (reset),
      .clr_i    (bus.clr_valid),
      .we_i     (bus.wr_valid),
      .waddr_i  (bus.wr_addr),
      .wdata_i  (bus.wr_subkey),
      .raddr_i  (raddr),
      .rdata_o  (rd_data),
      .rvalid_o (rd_vld)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         last_q     <= '0;
         dir_q      <= 1'b0;
         busy_q     <= 1'b0;
         rk_valid_q <= 1'b0;
         rk_data_q  <= '0;
         rk_idx_q   <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         // A new key invalidates the stream; this wins over a handshake.
         if (busy_q && bus.clr_valid) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            err_q      <= 1'b1;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (bus.start) begin
                     if (bus.key_len == KEY_LEN_NONE) begin
                        err_q <= 1'b1;
                     end else begin
                        dir_q   <= bus.decrypt;
                        idx_q   <= bus.decrypt ? nr_s : '0;
                        last_q  <= bus.decrypt ? '0 : nr_s;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                     end
                  end
               end
               S_WAIT: begin
                  if (rd_vld) begin
                     rk_data_q  <= rd_data;
                     rk_idx_q   <= idx_q;
                     rk_valid_q <= 1'b1;
                     state_q    <= S_PRESENT;
                  end
               end
               S_PRESENT: begin
                  if (hs) begin
                     if (idx_q == last_q) begin
                        rk_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                     end else begin
                        idx_q <= nxt;
                        if (rd_vld) begin
                           rk_data_q <= rd_data;
                           rk_idx_q  <= nxt;
                        end else begin
                           rk_valid_q <= 1'b0;
                           state_q    <= S_WAIT;
                        end
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.rk_valid = rk_valid_q;
   assign bus.rk_data  = rk_data_q;
   assign bus.rk_idx   = rk_idx_q;
   assign bus.rk_last  = rk_valid_q & (rk_idx_q == last_q);
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_aes_round_key_reader.sv
// Directed bench for the round-key reader: a queue-based stream model
// checked every cycle, plus literal expectations per scenario.
module tb_aes_round_key_reader;
   import aes_key_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   aes_round_key_reader_if bus();

   aes_round_key_reader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [KEY_W-1:0] mem_m [15];
   logic [14:0]      vb_m = '0;
   logic [14:0]      vtmp;
   int               exp_q[$];
   bit               busy_m = 0, done_exp = 0, err_exp = 0;
   bit               hold_prev = 0, seen_vld = 0;
   logic [KEY_W-1:0] prev_data;
   logic [3:0]       prev_idx;
   int cyc = 0, hs_cnt = 0, done_cnt = 0, last_cnt = 0, hold_cnt = 0;
   int start_cyc = 0, first_vld_cyc = 0, first_vld_idx = 0;
   int first_hs_cyc = 0, last_hs_cyc = 0, hs_since = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset) begin
         vb_m <= '0;
      end else begin
         vtmp = vb_m;
         if (bus.clr_valid) vtmp = '0;
         if (bus.wr_valid && bus.wr_addr != 4'd15) begin
            vtmp[bus.wr_addr] = 1'b1;
            mem_m[bus.wr_addr] <= bus.wr_subkey;
         end
         vb_m <= vtmp;
      end
   end

   always @(negedge clk) begin
      int nr;
      chk("busy", bus.busy, busy_m);
      chk("done", bus.done, done_exp);
      chk("err", bus.err, err_exp);
      chk("vbits", dut.u_mem.vbit_q, vb_m);
      chk("rk_last", bus.rk_last, bus.rk_valid && exp_q.size() == 1);
      if (bus.rk_valid) begin
         if (exp_q.size() == 0) chk("rk_valid_unexpected", 1, 0);
         else chk("rk_idx", bus.rk_idx, exp_q[0]);
         chk("rk_data", bus.rk_data, mem_m[bus.rk_idx]);
         if (!seen_vld) begin
            seen_vld = 1;
            first_vld_cyc = cyc;
            first_vld_idx = bus.rk_idx;
         end
      end
      if (hold_prev) begin
         chk("hold_valid", bus.rk_valid, 1);
         chk("hold_data", bus.rk_data, prev_data);
         chk("hold_idx", bus.rk_idx, prev_idx);
      end
      if (bus.done) done_cnt++;
      done_exp  = 0;
      err_exp   = 0;
      hold_prev = 0;
      if (!reset) begin
         busy_m = 0;
         exp_q.delete();
      end else if (busy_m && bus.clr_valid) begin
         err_exp = 1;
         busy_m  = 0;
         exp_q.delete();
      end else if (busy_m) begin
         if (bus.rk_valid && bus.rk_ready && exp_q.size() > 0) begin
            hs_cnt++;
            if (hs_since == 0) first_hs_cyc = cyc;
            hs_since++;
            last_hs_cyc = cyc;
            if (bus.rk_last) last_cnt++;
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
               done_exp = 1;
               busy_m   = 0;
            end
         end else if (bus.rk_valid) begin
            hold_prev = 1;
            hold_cnt++;
            prev_data = bus.rk_data;
            prev_idx  = bus.rk_idx;
         end
      end else if (bus.start) begin
         if (bus.key_len == 2'b00) begin
            err_exp = 1;
         end else begin
            nr = 8 + 2 * int'(bus.key_len);
            for (int k = 0; k <= nr; k++)
               exp_q.push_back(bus.decrypt ? nr - k : k);
            busy_m    = 1;
            start_cyc = cyc;
            seen_vld  = 0;
            hs_since  = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [KEY_W-1:0] key(int i, logic [7:0] salt);
      logic [7:0] b;
      b = 8'(i) ^ salt;
      return {16{b}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(int a, logic [KEY_W-1:0] d);
      bus.wr_valid  = 1'b1;
      bus.wr_addr   = 4'(a);
      bus.wr_subkey = d;
      tick();
      bus.wr_valid = 1'b0;
   endtask

   task automatic clr();
      bus.clr_valid = 1'b1;
      tick();
      bus.clr_valid = 1'b0;
   endtask

   task automatic go(logic [1:0] len, logic dec);
      bus.start   = 1'b1;
      bus.key_len = len;
      bus.decrypt = dec;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(int bound, string nm);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < bound && done_cnt == d0; i++) tick();
      chk(nm, done_cnt - d0, 1);
   endtask

   initial begin
      int hs0, w14;
      bus.wr_valid  = 0;
      bus.wr_addr   = '0;
      bus.wr_subkey = '0;
      bus.clr_valid = 0;
      bus.key_len   = 2'b00;
      bus.start     = 0;
      bus.decrypt   = 0;
      bus.rk_ready  = 0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_valid", bus.rk_valid, 0);
      chk("rst_data", bus.rk_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done_err", {bus.done, bus.err}, 0);
      chk("rst_vbits", dut.u_mem.vbit_q, 0);
      tick();
      reset = 1'b1;
      tick();

      // encrypt AES-128, memory prefilled, sink always ready
      for (int i = 0; i <= 10; i++) wr(i, key(i, 8'h00));
      bus.rk_ready = 1'b1;
      hs0 = hs_cnt;
      go(2'b01, 1'b0);
      wait_done(100, "t1_done");
      chk("t1_hs", hs_cnt - hs0, 11);
      chk("t1_latency", first_vld_cyc - start_cyc, 2);
      chk("t1_b2b", last_hs_cyc - first_hs_cyc, 10);
      chk("t1_last", last_cnt, 1);
      chk("t1_first_data", mem_m[0], 128'h0);

      // decrypt AES-256 from empty memory, slow writer
      clr();
      hs0 = hs_cnt;
      go(2'b11, 1'b1);
      w14 = 0;
      for (int i = 0; i <= 14; i++) begin
         wr(i, key(i, 8'h5A));
         if (i == 14) w14 = cyc;
         tick();
         tick();
      end
      wait_done(80, "t2_done");
      chk("t2_hs", hs_cnt - hs0, 15);
      chk("t2_first_idx", first_vld_idx, 14);
      chk("t2_first_after_w14", first_vld_cyc - w14, 1);
      chk("t2_key14", mem_m[14], {16{8'h54}});

      // encrypt AES-192 with a stuttering sink
      clr();
      for (int i = 0; i <= 12; i++) wr(i, key(i, 8'h33));
      hs0 = hs_cnt;
      hold_cnt = 0;
      go(2'b10, 1'b0);
      begin
         int d0;
         d0 = done_cnt;
         for (int i = 0; i < 100 && done_cnt == d0; i++) begin
            bus.rk_ready = ~bus.rk_ready;
            tick();
         end
         chk("t3_done_once", done_cnt - d0, 1);
      end
      chk("t3_hs", hs_cnt - hs0, 13);
      chk("t3_holds_seen", hold_cnt > 0, 1);

      // abort after four handshakes
      bus.rk_ready = 1'b1;
      clr();
      for (int i = 0; i <= 10; i++) wr(i, key(i, 8'hC3));
      hs0 = hs_cnt;
      go(2'b01, 1'b0);
      for (int i = 0; i < 100 && hs_cnt - hs0 < 4; i++) tick();
      bus.clr_valid = 1'b1;
      tick();
      bus.clr_valid = 1'b0;
      @(negedge clk);
      chk("t4_err", bus.err, 1);
      chk("t4_valid_low", bus.rk_valid, 0);
      chk("t4_busy_low", bus.busy, 0);
      chk("t4_hs", hs_cnt - hs0, 4);
      go(2'b01, 1'b0);
      repeat (5) tick();
      @(negedge clk);
      chk("t4_stall_valid", bus.rk_valid, 0);
      chk("t4_stall_busy", bus.busy, 1);
      clr();
      tick();

      // bad key length, clear+write ordering, ignored address
      go(2'b00, 1'b0);
      @(negedge clk);
      chk("t5_err", bus.err, 1);
      chk("t5_busy", bus.busy, 0);
      bus.clr_valid = 1'b1;
      wr(3, key(3, 8'h11));
      bus.clr_valid = 1'b0;
      @(negedge clk);
      chk("t5_vbit3", dut.u_mem.vbit_q, 15'h0008);
      wr(15, key(15, 8'h11));
      @(negedge clk);
      chk("t5_addr15", dut.u_mem.vbit_q, 15'h0008);
      tick();

      // reset in the middle of a stream
      clr();
      for (int i = 0; i <= 10; i++) wr(i, key(i, 8'h77));
      go(2'b01, 1'b0);
      begin
         bit hit;
         hit = 0;
         for (int i = 0; i < 60 && !hit; i++) begin
            tick();
            if (bus.rk_valid && bus.rk_idx == 4'd5) hit = 1;
         end
         chk("t6_reached_5", hit, 1);
      end
      reset = 1'b0;
      tick();
      @(negedge clk);
      chk("t6_valid", bus.rk_valid, 0);
      chk("t6_data_idx", {bus.rk_data, bus.rk_idx}, 0);
      chk("t6_flags", {bus.rk_last, bus.busy, bus.done, bus.err}, 0);
      chk("t6_vbits", dut.u_mem.vbit_q, 0);
      tick();
      reset = 1'b1;
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
